// File: rtl/dsd_proc_pkg.sv
// Shared definitions for the lab processor: field layout, address width derivation
// and the load-stage state encoding. Used by load, save and controller stages.
package dsd_proc_pkg;

    localparam int OPCODE_W = 2;

    function automatic int addr_w(input int mem_size);
        return $clog2(mem_size);
    endfunction

    function automatic int instr_w(input int aw);
        return 3 * aw + OPCODE_W;
    endfunction

    // Instruction layout, MSB to LSB: {opcode, src1, src2, dst}
    function automatic int dst_lsb(input int aw);
        return 0 * aw;
    endfunction

    function automatic int src2_lsb(input int aw);
        return aw;
    endfunction

    function automatic int src1_lsb(input int aw);
        return 2 * aw;
    endfunction

    function automatic int opcode_lsb(input int aw);
        return 3 * aw;
    endfunction

    localparam int LD_STATE_W = 3;

    localparam logic [LD_STATE_W-1:0] LD_IDLE   = 3'd0;
    localparam logic [LD_STATE_W-1:0] LD_READ_A = 3'd1;
    localparam logic [LD_STATE_W-1:0] LD_READ_B = 3'd2;
    localparam logic [LD_STATE_W-1:0] LD_CAPT_B = 3'd3;
    localparam logic [LD_STATE_W-1:0] LD_DONE   = 3'd4;

endpackage

// File: rtl/instr_field_decode.sv
// Combinational split of an instruction word into opcode, src1, src2 and dst.
// Shared between the load stage and the controller.
module instr_field_decode
    import dsd_proc_pkg::*;
#(
    parameter int AW = 6
) (
    input  logic [3*AW+OPCODE_W-1:0] i_instr,
    output logic [OPCODE_W-1:0]      o_opcode,
    output logic [AW-1:0]            o_src1,
    output logic [AW-1:0]            o_src2,
    output logic [AW-1:0]            o_dst
);

    localparam int OPC_LSB  = opcode_lsb(AW);
    localparam int SRC1_LSB = src1_lsb(AW);
    localparam int SRC2_LSB = src2_lsb(AW);
    localparam int DST_LSB  = dst_lsb(AW);

    assign o_opcode = i_instr[OPC_LSB  +: OPCODE_W];
    assign o_src1   = i_instr[SRC1_LSB +: AW];
    assign o_src2   = i_instr[SRC2_LSB +: AW];
    assign o_dst    = i_instr[DST_LSB  +: AW];

endmodule

// File: rtl/load_handler.sv
// Operand-fetch stage: reads src1/src2 from synchronous-read data memory and
// pulses ready with both operands. Optional macro: LOAD_SAME_ADDR_BYPASS_EN.
module load_handler
    import dsd_proc_pkg::*;
#(
    parameter int DATA_WIDTH        = 8,
    parameter int DATA_MEMORY_SIZE  = 64,
    parameter int INSTRUCTION_WIDTH = 3 * $clog2(DATA_MEMORY_SIZE) + 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                enable,
    input  logic [INSTRUCTION_WIDTH-1:0]        instruction,
    input  logic [DATA_WIDTH-1:0]               mem_data_in,
    output logic [$clog2(DATA_MEMORY_SIZE)-1:0] mem_addr,
    output logic                                mem_rd_en,
    output logic [DATA_WIDTH-1:0]               operand_a,
    output logic [DATA_WIDTH-1:0]               operand_b,
    output logic [1:0]                          opcode_out,
    output logic [$clog2(DATA_MEMORY_SIZE)-1:0] dst_addr_out,
    output logic                                ready
);

    localparam int AW = addr_w(DATA_MEMORY_SIZE);

    logic [OPCODE_W-1:0]   w_opcode;
    logic [AW-1:0]         w_src1;
    logic [AW-1:0]         w_src2;
    logic [AW-1:0]         w_dst;

    logic [LD_STATE_W-1:0] r_state;
    logic [AW-1:0]         r_src2;
    logic [AW-1:0]         r_mem_addr;
    logic                  r_mem_rd_en;
    logic [DATA_WIDTH-1:0] r_operand_a;
    logic [DATA_WIDTH-1:0] r_operand_b;
    logic [OPCODE_W-1:0]   r_opcode;
    logic [AW-1:0]         r_dst;
    logic                  r_ready;
`ifdef LOAD_SAME_ADDR_BYPASS_EN
    logic                  r_same;
`endif

    instr_field_decode #(
        .AW(AW)
    ) u_decode (
        .i_instr (instruction),
        .o_opcode(w_opcode),
        .o_src1  (w_src1),
        .o_src2  (w_src2),
        .o_dst   (w_dst)
    );

    // Memory samples mem_addr at the edge after it is set; data is captured one edge later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= LD_IDLE;
            r_src2      <= '0;
            r_mem_addr  <= '0;
            r_mem_rd_en <= 1'b0;
            r_operand_a <= '0;
            r_operand_b <= '0;
            r_opcode    <= '0;
            r_dst       <= '0;
            r_ready     <= 1'b0;
`ifdef LOAD_SAME_ADDR_BYPASS_EN
            r_same      <= 1'b0;
`endif
        end else begin
            case (r_state)
                LD_IDLE: begin
                    r_ready <= 1'b0;
                    if (enable) begin
                        r_opcode    <= w_opcode;
                        r_dst       <= w_dst;
                        r_src2      <= w_src2;
                        r_mem_addr  <= w_src1;
                        r_mem_rd_en <= 1'b1;
`ifdef LOAD_SAME_ADDR_BYPASS_EN
                        r_same      <= (w_src1 == w_src2);
`endif
                        r_state     <= LD_READ_A;
                    end
                end
                LD_READ_A: begin
                    if (!enable) begin
                        r_mem_rd_en <= 1'b0;
                        r_ready     <= 1'b0;
                        r_state     <= LD_IDLE;
`ifdef LOAD_SAME_ADDR_BYPASS_EN
                    end else if (r_same) begin
                        r_mem_rd_en <= 1'b0;
                        r_state     <= LD_CAPT_B;
`endif
                    end else begin
                        r_mem_addr  <= r_src2;
                        r_mem_rd_en <= 1'b1;
                        r_state     <= LD_READ_B;
                    end
                end
                LD_READ_B: begin
                    r_mem_rd_en <= 1'b0;
                    if (!enable) begin
                        r_ready <= 1'b0;
                        r_state <= LD_IDLE;
                    end else begin
                        r_operand_a <= mem_data_in;
                        r_state     <= LD_CAPT_B;
                    end
                end
                LD_CAPT_B: begin
                    r_mem_rd_en <= 1'b0;
                    if (!enable) begin
                        r_ready <= 1'b0;
                        r_state <= LD_IDLE;
                    end else begin
`ifdef LOAD_SAME_ADDR_BYPASS_EN
                        if (r_same) begin
                            r_operand_a <= mem_data_in;
                        end
`endif
                        r_operand_b <= mem_data_in;
                        r_ready     <= 1'b1;
                        r_state     <= LD_DONE;
                    end
                end
                LD_DONE: begin
                    // Parked here while the controller still holds enable, so no re-reads occur.
                    r_ready     <= 1'b0;
                    r_mem_rd_en <= 1'b0;
                    if (!enable) begin
                        r_state <= LD_IDLE;
                    end
                end
                default: begin
                    r_ready     <= 1'b0;
                    r_mem_rd_en <= 1'b0;
                    r_state     <= LD_IDLE;
                end
            endcase
        end
    end

    assign mem_addr     = r_mem_addr;
    assign mem_rd_en    = r_mem_rd_en;
    assign operand_a    = r_operand_a;
    assign operand_b    = r_operand_b;
    assign opcode_out   = r_opcode;
    assign dst_addr_out = r_dst;
    assign ready        = r_ready;

endmodule

// File: tb/tb_load_handler.sv
// Scoreboard bench for load_handler with a synchronous-read memory model.
// Honours LOAD_SAME_ADDR_BYPASS_EN for the same-address expectations.
module tb_load_handler;

    localparam int DW = 8;
    localparam int MS = 64;
    localparam int AW = 6;
    localparam int IW = 3 * AW + 2;

`ifdef LOAD_SAME_ADDR_BYPASS_EN
    localparam int SAME_LAT   = 2;
    localparam int SAME_READS = 1;
`else
    localparam int SAME_LAT   = 3;
    localparam int SAME_READS = 2;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [IW-1:0] instruction;
    logic [DW-1:0] mem_data_in = '0;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic [DW-1:0] operand_a;
    logic [DW-1:0] operand_b;
    logic [1:0]    opcode_out;
    logic [AW-1:0] dst_addr_out;
    logic          ready;

    load_handler #(
        .DATA_WIDTH       (DW),
        .DATA_MEMORY_SIZE (MS),
        .INSTRUCTION_WIDTH(IW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .instruction (instruction),
        .mem_data_in (mem_data_in),
        .mem_addr    (mem_addr),
        .mem_rd_en   (mem_rd_en),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .opcode_out  (opcode_out),
        .dst_addr_out(dst_addr_out),
        .ready       (ready)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [MS];

    always @(posedge clk) begin
        if (mem_rd_en) mem_data_in <= mem[mem_addr];
    end

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [1:0]    op;
        logic [AW-1:0] dst;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   rd_total = 0;
    int   rdy_total = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mem_rd_en) rd_total++;
        if (ready) begin
            rdy_total++;
            if (sbq.size() == 0) begin
                chk("sb_unexpected_ready", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("sb_operand_a", 32'(operand_a), 32'(e.a));
                chk("sb_operand_b", 32'(operand_b), 32'(e.b));
                chk("sb_opcode", 32'(opcode_out), 32'(e.op));
                chk("sb_dst", 32'(dst_addr_out), 32'(e.dst));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_rd_en"}, 32'(mem_rd_en), 32'd0);
        chk({tag, "_operand_a"}, 32'(operand_a), 32'd0);
        chk({tag, "_operand_b"}, 32'(operand_b), 32'd0);
        chk({tag, "_opcode"}, 32'(opcode_out), 32'd0);
        chk({tag, "_dst"}, 32'(dst_addr_out), 32'd0);
        chk({tag, "_ready"}, 32'(ready), 32'd0);
    endtask

    task automatic fetch(input logic [1:0] op, input int s1, input int s2, input int d,
                         input int exp_lat, input int exp_reads, input int hold);
        exp_t e;
        int   rd0, rdy0, n;
        logic [AW-1:0] a1, a2, ad;
        a1 = s1[AW-1:0];
        a2 = s2[AW-1:0];
        ad = d[AW-1:0];
        e.a = mem[a1];
        e.b = mem[a2];
        e.op = op;
        e.dst = ad;
        sbq.push_back(e);
        rd0 = rd_total;
        rdy0 = rdy_total;
        instruction = {op, a1, a2, ad};
        enable = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1) instruction = ~instruction;
        end while (!ready && n < 20);
        chk("latency", 32'(n - 1), 32'(exp_lat));
        repeat (hold) tick();
        enable = 1'b0;
        tick();
        tick();
        chk("ready_pulses", 32'(rdy_total - rdy0), 32'd1);
        chk("read_cycles", 32'(rd_total - rd0), 32'(exp_reads));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rdy0, s1, s2;
        rst = 1'b1;
        enable = 1'b0;
        instruction = '0;
        for (int i = 0; i < MS; i++) mem[i] = 8'($urandom);
        mem[3]  = 8'h5A;
        mem[7]  = 8'hC3;
        mem[63] = 8'hFF;
        mem[0]  = 8'h00;
        mem[9]  = 8'h11;
        mem[5]  = 8'h3C;

        tick();
        tick();
        chk_zero("reset");
        rst = 1'b0;
        tick();

        // Basic fetch followed by 10 cycles of held enable
        fetch(2'b01, 3, 7, 12, 3, 2, 10);
        fetch(2'b10, 0, 63, 33, 3, 2, 0);
        chk("held_opa", 32'(operand_a), 32'h00);
        chk("held_opb", 32'(operand_b), 32'hFF);

        // Abort: enable dropped so that it is sampled low at E2
        rdy0 = rdy_total;
        instruction = {2'b11, 6'd3, 6'd9, 6'd1};
        enable = 1'b1;
        tick();
        tick();
        enable = 1'b0;
        repeat (5) tick();
        chk("abort_ready_pulses", 32'(rdy_total - rdy0), 32'd0);
        chk("abort_opa_kept", 32'(operand_a), 32'h00);
        chk("abort_opb_kept", 32'(operand_b), 32'hFF);
        chk("abort_rd_en", 32'(mem_rd_en), 32'd0);

        // Reset sampled at E1
        instruction = {2'b10, 6'd3, 6'd7, 6'd5};
        enable = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        chk_zero("rst_mid");
        rst = 1'b0;
        enable = 1'b0;
        tick();
        fetch(2'b11, 7, 3, 40, 3, 2, 0);

        // Same source address
        fetch(2'b00, 5, 5, 20, SAME_LAT, SAME_READS, 2);
        chk("same_opa", 32'(operand_a), 32'h3C);
        chk("same_opb", 32'(operand_b), 32'h3C);

        for (int k = 0; k < 4; k++) begin
            s1 = int'($urandom_range(0, MS - 1));
            s2 = (s1 + 1 + int'($urandom_range(0, MS - 2))) % MS;
            fetch(2'($urandom), s1, s2, int'($urandom_range(0, MS - 1)), 3, 2, k);
        end

        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
